// File: rtl/rom_stream_reader_pkg.sv
// ============================================================================
//  Module   : rom_stream_reader_pkg
//  Purpose  : State encoding and helpers shared by the ROM stream reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rom_stream_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_DRAIN = ST_DRAIN
    } state_t;

    // A full 2-entry buffer can still take a word if the head leaves this cycle.
    function automatic logic can_push(input logic [1:0] count, input logic pop);
        return (count < 2'd2) || pop;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_stream_reader_if.sv
// ============================================================================
//  Module   : rom_stream_reader_if
//  Purpose  : ROM address/data pair plus the valid/ready output stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rom_stream_reader_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output rom_addr, out_data, out_last, out_valid,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_addr, out_data, out_last, out_valid,
        output rom_data, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader_stream_fifo2.sv
// ============================================================================
//  Module   : stream_fifo2
//  Purpose  : Two-entry in-order buffer; head is always presented on o_head.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_fifo2
    import rom_stream_reader_pkg::*;
#(
    parameter int DW = 9
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic          i_flush,
    input  wire logic [DW-1:0] i_data,
    output logic      [DW-1:0] o_head,
    output logic      [1:0]    o_count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign w_push  = i_push && can_push(r_count, w_pop);
    assign o_head  = r_head;
    assign o_count = r_count;

    // Head only changes on a pop or when written into an empty slot,
    // which keeps the output stable across a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) r_tail <= i_data;
                        else        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// ============================================================================
//  Module   : rom_stream_reader
//  Purpose  : Burst-reads an async ROM and emits the words as a valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           start,
    input  wire logic           abort,
    input  wire logic [AW-1:0]  base_addr,
    input  wire logic [AW:0]    len,
    rom_stream_reader_if.master bus,
    output logic                busy,
    output logic                done
);

    state_t         r_state;
    state_t         w_next;
    logic [AW-1:0]  r_rom_addr;
    logic [AW:0]    r_remaining;
    logic           r_done;

    logic           w_push;
    logic           w_pop;
    logic           w_load;
    logic           w_zero_done;
    logic           w_fin;
    logic [1:0]     w_count;
    logic [WIDTH:0] w_head;
    logic           w_last_word;

    assign w_pop       = bus.out_valid && bus.out_ready;
    assign w_last_word = (r_remaining == (AW+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_load      = 1'b0;
        w_zero_done = 1'b0;
        w_fin       = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            w_load = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_zero_done = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (can_push(w_count, w_pop)) begin
                        w_push = 1'b1;
                        if (w_last_word) w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave on the edge that empties the buffer so done follows the last accept directly.
                    if ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) begin
                        w_fin  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr  <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zero_done || w_fin;
            if (abort) begin
                r_remaining <= '0;
            end else if (w_load) begin
                r_rom_addr  <= base_addr;
                r_remaining <= len;
            end else if (w_push) begin
                r_rom_addr  <= r_rom_addr + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

    stream_fifo2 #(
        .DW (WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (abort),
        .i_data  ({bus.rom_data, w_last_word}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = (w_count != 2'd0);
    assign bus.out_data  = w_head[WIDTH:1];
    assign bus.out_last  = bus.out_valid && w_head[0];
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ============================================================================
//  Module   : tb_rom_stream_reader
//  Purpose  : Directed self-checking bench for rom_stream_reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_data [0:511];
    logic       cap_last [0:511];
    int cap_n, done_iter, last_iter, busy_cycles, done_pulses, stall_err, max_cnt;

    rom_stream_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    rom_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM contents model
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return (a ^ 8'hA5) + {a[6:0], a[7]};
    endfunction

    assign bus.rom_data = rom_f(bus.rom_addr);

    task automatic kick(input logic [7:0] b, input logic [8:0] l);
        @(negedge clk);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
    task automatic collect(input int mode, input int stop_after, input int budget);
        logic       pv, pr, pl, r;
        logic [7:0] pd;
        cap_n = 0; done_iter = -1; last_iter = -1; busy_cycles = 0;
        done_pulses = 0; stall_err = 0; max_cnt = 0;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h00;
        for (int i = 0; i < budget; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_iter < 0) done_iter = i;
            end
            if (int'(dut.w_count) > max_cnt) max_cnt = int'(dut.w_count);
            if (pv && !pr && (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl))
                stall_err++;
            r = (mode == 0) || (i % 4 == 0) || (i % 4 == 3);
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                cap_data[cap_n] = bus.out_data;
                cap_last[cap_n] = bus.out_last;
                cap_n++;
                last_iter = i;
            end
            pv = bus.out_valid; pr = r; pd = bus.out_data; pl = bus.out_last;
            if (done_iter >= 0 && i >= done_iter + 2) break;
            if (stop_after > 0 && cap_n >= stop_after) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", bus.out_last); end
        n_tests++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
        n_tests++; if (bus.rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus.rom_addr); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        kick(8'h10, 9'd4);
        n_tests++; if (bus.rom_addr !== 8'h10) begin n_fail++; $display("FAIL basic_addr_load: got %h want 10", bus.rom_addr); end
        collect(0, 0, 50);
        n_tests++; if (cap_n != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", cap_n); end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            n_tests++;
            if (cap_data[i] !== rom_f(8'h10 + 8'(i)) || cap_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h/%0b want %h/%0b", i, cap_data[i], cap_last[i], rom_f(8'h10 + 8'(i)), (i == 3));
            end
        end
        n_tests++; if (done_iter != last_iter + 1) begin n_fail++; $display("FAIL basic_done_timing: got iter %0d want %0d", done_iter, last_iter + 1); end
        n_tests++; if (busy_cycles != 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 5", busy_cycles); end
        n_tests++; if (done_pulses != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); end
    endtask

    task automatic test_wrap;
        logic [7:0] a;
        kick(8'hFE, 9'd4);
        collect(0, 0, 50);
        n_tests++; if (cap_n != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", cap_n); end
        for (int i = 0; i < 4 && i < cap_n; i++) begin
            a = 8'hFE + 8'(i);
            n_tests++;
            if (cap_data[i] !== rom_f(a)) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h want %h (addr %h)", i, cap_data[i], rom_f(a), a);
            end
        end
    endtask

    task automatic test_stall;
        int bad;
        kick(8'h55, 9'd8);
        collect(1, 0, 100);
        bad = 0;
        for (int i = 0; i < cap_n; i++)
            if (cap_data[i] !== rom_f(8'h55 + 8'(i)) || cap_last[i] !== (i == 7)) bad++;
        n_tests++; if (cap_n != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", cap_n); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_words: got %0d bad words want 0", bad); end
        n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        n_tests++; if (max_cnt > 2) begin n_fail++; $display("FAIL stall_maxcount: got %0d want <=2", max_cnt); end
        n_tests++; if (done_pulses != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_pulses); end
    endtask

    task automatic test_zero_len;
        kick(8'h20, 9'd0);
        collect(0, 0, 20);
        n_tests++; if (cap_n != 0) begin n_fail++; $display("FAIL zero_words: got %0d want 0", cap_n); end
        n_tests++; if (done_iter != 0) begin n_fail++; $display("FAIL zero_done_timing: got iter %0d want 0", done_iter); end
        n_tests++; if (busy_cycles != 0) begin n_fail++; $display("FAIL zero_busy: got %0d want 0", busy_cycles); end
        n_tests++; if (done_pulses != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_pulses); end
    endtask

    task automatic test_abort;
        int extra_done;
        kick(8'h20, 9'd16);
        collect(0, 5, 100);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0b want 0", bus.out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy); end
        n_tests++; if (bus.rom_addr !== 8'h26) begin n_fail++; $display("FAIL abort_addr_hold: got %h want 26", bus.rom_addr); end
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || bus.out_valid) extra_done++;
            @(negedge clk);
        end
        n_tests++; if (extra_done != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d cycles of done/valid want 0", extra_done); end
        bus.out_ready = 1'b1;
        kick(8'h40, 9'd2);
        collect(0, 0, 50);
        n_tests++;
        if (cap_n != 2 || cap_data[0] !== rom_f(8'h40) || cap_data[1] !== rom_f(8'h41) || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: got n=%0d %h/%0b %h/%0b want n=2 %h/0 %h/1", cap_n, cap_data[0], cap_last[0], cap_data[1], cap_last[1], rom_f(8'h40), rom_f(8'h41));
        end
    endtask

    task automatic test_async_reset;
        int bad, lasts;
        kick(8'h80, 9'd16);
        collect(0, 3, 100);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_valid_busy: got %0b%0b want 00", bus.out_valid, busy); end
        n_tests++; if (bus.rom_addr !== 8'h00 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
            n_fail++; $display("FAIL areset_outputs: got addr %h data %h last %0b want 00 00 0", bus.rom_addr, bus.out_data, bus.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        kick(8'h33, 9'd256);
        collect(0, 0, 400);
        bad = 0; lasts = 0;
        for (int i = 0; i < cap_n; i++) begin
            if (cap_data[i] !== rom_f(8'h33 + 8'(i))) bad++;
            if (cap_last[i] === 1'b1) begin
                if (i != 255) bad++;
                lasts++;
            end
        end
        n_tests++; if (cap_n != 256) begin n_fail++; $display("FAIL full_count: got %0d want 256", cap_n); end
        n_tests++; if (bad != 0 || lasts != 1) begin n_fail++; $display("FAIL full_words: got %0d bad, %0d lasts want 0, 1", bad, lasts); end
        n_tests++; if (busy_cycles != 257) begin n_fail++; $display("FAIL full_busy: got %0d want 257", busy_cycles); end
        n_tests++; if (done_pulses != 1) begin n_fail++; $display("FAIL full_done: got %0d want 1", done_pulses); end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        base_addr     = 8'h00;
        len           = 9'd0;
        bus.out_ready = 1'b1;
        test_reset;
        test_basic;
        test_wrap;
        test_stall;
        test_zero_len;
        test_abort;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
